// File: rtl/dbus_access_ctrl_pkg.sv
// Shared types for the memory-stage data bus controller: access size, byte
// strobe, scalar aliases, controller state and the alignment rule.
package dbus_access_ctrl_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } dac_state_t;

    // An access is aligned when the low address bits below its size are zero.
    function automatic logic is_misaligned(input logic [2:0] addr, input msize_t msize);
        logic mis;
        case (msize)
            MSIZE2:  mis = addr[0];
            MSIZE4:  mis = |addr[1:0];
            MSIZE8:  mis = |addr[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_access_ctrl_datamem.sv
// Byte-lane alignment for store data/strobes and right-alignment plus
// sign/zero extension for load data.
module Datamem
    import dbus_access_ctrl_pkg::*;
(
    input  logic [2:0] addr,
    input  msize_t     msize,
    input  u1          is_unsigned,
    input  u64         raw_wd,
    output u64         wd,
    output strobe_t    strobe,
    input  u64         raw_rd,
    output u64         rd
);

    logic [5:0] shamt;
    u64         shifted;
    strobe_t    base_strobe;

    assign shamt = {addr, 3'b000};

    always_comb begin
        wd      = raw_wd << shamt;
        shifted = raw_rd >> shamt;
        case (msize)
            MSIZE1: begin
                base_strobe = 8'h01;
                rd = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            end
            MSIZE2: begin
                base_strobe = 8'h03;
                rd = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            end
            MSIZE4: begin
                base_strobe = 8'h0F;
                rd = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                base_strobe = 8'hFF;
                rd = shifted;
            end
        endcase
        strobe = base_strobe << addr;
    end

endmodule

// File: rtl/dbus_access_ctrl.sv
// Memory-stage controller: sequences one load/store onto the data bus, holds
// the request until data_ok, and returns the extended result to writeback.
module dbus_access_ctrl
    import dbus_access_ctrl_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_is_store,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  msize_t        in_msize,
    input  logic          in_unsigned,
    input  logic          flush,
    output logic          dreq_valid,
    output logic [AW-1:0] dreq_addr,
    output msize_t        dreq_size,
    output strobe_t       dreq_strobe,
    output logic [DW-1:0] dreq_data,
    input  logic          dresp_data_ok,
    input  logic [DW-1:0] dresp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_rdata,
    output logic          out_misalign,
    output logic          busy
);

    dac_state_t    state;
    logic [AW-1:0] addr_q;
    msize_t        size_q;
    u1             store_q;
    u1             unsigned_q;
    u1             killed_q;
    u1             misalign_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    u64      lane_wd;
    u64      ext_rd;
    strobe_t lane_strobe;

    Datamem u_datamem (
        .addr        (addr_q[2:0]),
        .msize       (size_q),
        .is_unsigned (unsigned_q),
        .raw_wd      (wdata_q),
        .wd          (lane_wd),
        .strobe      (lane_strobe),
        .raw_rd      (dresp_data),
        .rd          (ext_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= MSIZE1;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            killed_q   <= 1'b0;
            misalign_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        addr_q     <= in_addr;
                        size_q     <= in_msize;
                        store_q    <= in_is_store;
                        unsigned_q <= in_unsigned;
                        wdata_q    <= in_wdata;
                        rdata_q    <= '0;
                        killed_q   <= 1'b0;
                        // Misaligned ops report straight back without touching the bus.
                        if (is_misaligned(in_addr[2:0], in_msize)) begin
                            misalign_q <= 1'b1;
                            state      <= RESP;
                        end else begin
                            misalign_q <= 1'b0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) killed_q <= 1'b1;
                    // The bus cycle always runs to completion; a flush only drops its result.
                    if (dresp_data_ok) begin
                        rdata_q <= store_q ? '0 : ext_rd;
                        state   <= (killed_q || flush) ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (flush || out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign dreq_valid   = (state == REQ);
    assign dreq_addr    = addr_q;
    assign dreq_size    = size_q;
    assign dreq_strobe  = store_q ? lane_strobe : 8'h00;
    assign dreq_data    = lane_wd;
    assign out_valid    = (state == RESP) && !flush;
    assign out_rdata    = rdata_q;
    assign out_misalign = misalign_q;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Directed bench for dbus_access_ctrl: loads, stores, misalignment, flush,
// writeback backpressure and reset in the middle of a bus request.
module tb_dbus_access_ctrl;
    import dbus_access_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    msize_t      in_msize;
    logic        in_unsigned;
    logic        flush;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    msize_t      dreq_size;
    strobe_t     dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_misalign;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dbus_access_ctrl #(.AW(64), .DW(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_store   (in_is_store),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_msize      (in_msize),
        .in_unsigned   (in_unsigned),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_misalign  (out_misalign),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic st, input logic [63:0] a, input msize_t sz,
                           input logic uns, input logic [63:0] wd);
        @(negedge clk);
        in_valid    = 1'b1;
        in_is_store = st;
        in_addr     = a;
        in_msize    = sz;
        in_unsigned = uns;
        in_wdata    = wd;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, dreq_valid, out_valid, out_misalign} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 10000",
                               {in_ready, busy, dreq_valid, out_valid, out_misalign});
        end
        checks++;
        if ({out_rdata, dreq_data, dreq_addr, dreq_strobe} !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                               out_rdata, dreq_data, dreq_addr, dreq_strobe);
        end
        reset = 1'b0;
    endtask

    task automatic test_aligned_load();
        present(1'b0, 64'h0000_0000_1000_0003, MSIZE1, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dreq_valid !== 1'b1 || dreq_strobe !== 8'h00 || busy !== 1'b1) begin
                errors++; $display("FAIL lb_req_%0d: got valid=%b strobe=%h busy=%b expected 1/00/1",
                                   i, dreq_valid, dreq_strobe, busy);
            end
            checks++;
            if (dreq_addr !== 64'h0000_0000_1000_0003 || dreq_size !== MSIZE1) begin
                errors++; $display("FAIL lb_addr_%0d: got %h size=%0d expected 10000003 size=0",
                                   i, dreq_addr, dreq_size);
            end
            if (i == 2) begin
                dresp_data_ok = 1'b1;
                dresp_data    = 64'h0000_0000_8000_0000;
            end
            @(negedge clk);
        end
        dresp_data_ok = 1'b0;
        dresp_data    = 64'h0;
        checks++;
        if (out_valid !== 1'b1 || dreq_valid !== 1'b0 || out_misalign !== 1'b0) begin
            errors++; $display("FAIL lb_resp: got out_valid=%b dreq_valid=%b mis=%b expected 1/0/0",
                               out_valid, dreq_valid, out_misalign);
        end
        checks++;
        if (out_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++; $display("FAIL lb_rdata: got %h expected ffffffffffffff80", out_rdata);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL lb_done: got in_ready=%b out_valid=%b expected 1/0",
                               in_ready, out_valid);
        end
    endtask

    task automatic test_aligned_store();
        present(1'b1, 64'h0000_0000_2000_0006, MSIZE2, 1'b0, 64'h0000_0000_0000_1234);
        checks++;
        if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0) begin
            errors++; $display("FAIL sh_strobe: got valid=%b strobe=%h expected 1/c0",
                               dreq_valid, dreq_strobe);
        end
        checks++;
        if (dreq_data !== 64'h1234_0000_0000_0000) begin
            errors++; $display("FAIL sh_data: got %h expected 1234000000000000", dreq_data);
        end
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== 64'h0) begin
            errors++; $display("FAIL sh_resp: got out_valid=%b rdata=%h expected 1/0",
                               out_valid, out_rdata);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        present(1'b0, 64'h0000_0000_3000_0002, MSIZE4, 1'b0, 64'h0);
        checks++;
        if (out_valid !== 1'b1 || out_misalign !== 1'b1 || dreq_valid !== 1'b0) begin
            errors++; $display("FAIL lw_misalign: got out_valid=%b mis=%b dreq=%b expected 1/1/0",
                               out_valid, out_misalign, dreq_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
            errors++; $display("FAIL lw_misalign_done: got in_ready=%b dreq=%b expected 1/0",
                               in_ready, dreq_valid);
        end
    endtask

    task automatic test_flush_req();
        present(1'b0, 64'h0000_0000_4000_0008, MSIZE8, 1'b0, 64'h0);
        flush = 1'b1;
        checks++;
        if (dreq_valid !== 1'b1) begin
            errors++; $display("FAIL ld_flush_req0: got %b expected 1", dreq_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            flush = 1'b0;
            checks++;
            if (dreq_valid !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL ld_flush_hold_%0d: got dreq=%b out_valid=%b expected 1/0",
                                   i, dreq_valid, out_valid);
            end
        end
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1111_2222_3333_4444;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dreq_valid !== 1'b0) begin
            errors++; $display("FAIL ld_flush_done: got in_ready=%b out_valid=%b dreq=%b expected 1/0/0",
                               in_ready, out_valid, dreq_valid);
        end
    endtask

    task automatic test_flush_with_data_ok();
        present(1'b0, 64'h0000_0000_4000_0010, MSIZE8, 1'b0, 64'h0);
        flush         = 1'b1;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        dresp_data_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_dok_same: got in_ready=%b out_valid=%b expected 1/0",
                               in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        present(1'b0, 64'h0000_0000_5000_0010, MSIZE8, 1'b0, 64'h0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1122_3344_5566_7788;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_data    = 64'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rdata !== 64'h1122_3344_5566_7788 ||
                busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b rd=%h busy=%b rdy=%b expected 1/1122334455667788/1/0",
                                   i, out_valid, out_rdata, busy, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_handshake: got v=%b rdy=%b expected 1/0", out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: got rdy=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_extend();
        present(1'b0, 64'h0000_0000_6000_0002, MSIZE2, 1'b1, 64'h0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8001_0000;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        checks++;
        if (out_rdata !== 64'h0000_0000_0000_8001) begin
            errors++; $display("FAIL lhu_rdata: got %h expected 0000000000008001", out_rdata);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        present(1'b0, 64'h0000_0000_6000_0004, MSIZE4, 1'b0, 64'h0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h8765_4321_0000_0000;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        checks++;
        if (out_rdata !== 64'hFFFF_FFFF_8765_4321) begin
            errors++; $display("FAIL lw_rdata: got %h expected ffffffff87654321", out_rdata);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        present(1'b1, 64'h0000_0000_7000_0004, MSIZE4, 1'b0, 64'hAABB_CCDD);
        checks++;
        if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hF0) begin
            errors++; $display("FAIL rst_req_pre: got dreq=%b strobe=%h expected 1/f0",
                               dreq_valid, dreq_strobe);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dreq_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_req_post: got dreq=%b out_valid=%b rdy=%b expected 0/0/1",
                               dreq_valid, out_valid, in_ready);
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_is_store   = 1'b0;
        in_addr       = '0;
        in_wdata      = '0;
        in_msize      = MSIZE1;
        in_unsigned   = 1'b0;
        flush         = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        out_ready     = 1'b0;
        test_reset();
        test_aligned_load();
        test_aligned_store();
        test_misaligned();
        test_flush_req();
        test_flush_with_data_ok();
        test_backpressure();
        test_extend();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
